fp_mant_divsqrt: RTL and testbench

Parametrised iterative mantissa divide / square-root engine for the single-precision FPU datapath. It takes normalised significands and produces a fixed-point quotient or root with guard bits and a sticky bit, one result bit per clock, for the rounding stage to consume. It generalises the fixed-width divider iteration with a selectable mode, an odd-exponent sqrt pre-scale, a tag passthrough, and a kill path. It sits between the operand-unpack stage and the rounding stage.

---
 rtl/fp_mant_divsqrt.sv | 174 +++++++++++++++++
 tb/tb_fp_mant_divsqrt.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mant_divsqrt.sv
// Iterative mantissa divide / square-root engine, one result bit per clock.
// Produces a Q-bit fixed-point quotient or root plus a sticky bit for rounding.
module fp_mant_divsqrt #(
    parameter int WIDTH = 24,
    parameter int EXTRA = 2,
    parameter int TAG_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   kill,
    input  logic                   op,
    input  logic                   odd,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [TAG_W-1:0]       tag_i,
    output logic                   busy,
    output logic                   ready,
    output logic [WIDTH+EXTRA-1:0] quotient,
    output logic                   sticky,
    output logic [TAG_W-1:0]       tag_o
);
    localparam int Q   = WIDTH + EXTRA;
    localparam int CW  = $clog2(Q);
    localparam int RW  = Q + 2;
    localparam int PAD = 2 * Q - WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [2*Q-1:0]   rad_q, rad_d;
    logic [Q-1:0]     root_q, root_d;
    logic [Q-1:0]     res_q, res_d;
    logic             sticky_q, sticky_d;
    logic [TAG_W-1:0] tago_q, tago_d;

    logic             accept;
    logic             last;
    logic [WIDTH:0]   x_ext;
    logic [RW-1:0]    div_ext;
    logic             d_ge;
    logic [RW-1:0]    d_sub;
    logic [RW-1:0]    d_rs;
    logic [RW-1:0]    s_cur;
    logic [RW-1:0]    s_trial;
    logic             s_ge;
    logic [RW-1:0]    s_sub;
    logic             unused_bits;

    assign accept  = enable && (state_q != CALC);
    assign last    = (state_q == CALC) && (cnt_q == '0);
    assign x_ext   = odd ? {a, 1'b0} : {1'b0, a};

    // Restoring divide step: compare, conditionally subtract, shift.
    assign div_ext = {{(RW - WIDTH){1'b0}}, div_q};
    assign d_ge    = rem_q >= div_ext;
    assign d_sub   = rem_q - div_ext;
    assign d_rs    = d_ge ? d_sub : rem_q;

    // Restoring sqrt step: bring down two radicand bits, trial = (root<<2)|01.
    assign s_cur   = {rem_q[Q-1:0], rad_q[2*Q-1 -: 2]};
    assign s_trial = {root_q, 2'b01};
    assign s_ge    = s_cur >= s_trial;
    assign s_sub   = s_cur - s_trial;

    assign unused_bits = d_rs[RW-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            tag_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            rad_q    <= '0;
            root_q   <= '0;
            res_q    <= '0;
            sticky_q <= 1'b0;
            tago_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            rad_q    <= rad_d;
            root_q   <= root_d;
            res_q    <= res_d;
            sticky_q <= sticky_d;
            tago_q   <= tago_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = CALC;
            end
            CALC: begin
                if (kill)             state_d = IDLE;
                else if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                state_d = enable ? CALC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        tag_d    = tag_q;
        div_d    = div_q;
        rem_d    = rem_q;
        rad_d    = rad_q;
        root_d   = root_q;
        res_d    = res_q;
        sticky_d = sticky_q;
        tago_d   = tago_q;
        if (accept) begin
            op_d   = op;
            tag_d  = tag_i;
            div_d  = b;
            cnt_d  = CW'(Q - 1);
            root_d = '0;
            if (op) begin
                rem_d = '0;
                rad_d = {x_ext, {PAD{1'b0}}};
            end else begin
                rem_d = {{(RW - WIDTH){1'b0}}, a};
                rad_d = '0;
            end
        end else if (state_q == CALC) begin
            cnt_d = cnt_q - CW'(1);
            if (op_q) begin
                rem_d  = s_ge ? s_sub : s_cur;
                root_d = {root_q[Q-2:0], s_ge};
                rad_d  = {rad_q[2*Q-3:0], 2'b00};
            end else begin
                rem_d  = {d_rs[RW-2:0], 1'b0};
                root_d = {root_q[Q-2:0], d_ge};
            end
            // A kill on the final edge must leave the previous result intact.
            if (last && !kill) begin
                res_d    = root_d;
                sticky_d = |rem_d;
                tago_d   = tag_q;
            end
        end
    end

    always_comb begin
        busy  = (state_q == CALC);
        ready = (state_q == DONE);
    end

    assign quotient = res_q;
    assign sticky   = sticky_q;
    assign tag_o    = tago_q;

endmodule

// File: tb/tb_fp_mant_divsqrt.sv
// Bench for fp_mant_divsqrt: arithmetic reference model, per-cycle compare,
// directed control scenarios and randomized traffic.
module tb_fp_mant_divsqrt;
    localparam int WIDTH = 24;
    localparam int EXTRA = 2;
    localparam int TAG_W = 4;
    localparam int Q     = WIDTH + EXTRA;
    localparam int LAT   = Q + 1;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             kill;
    logic             op;
    logic             odd;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag_i;
    logic             busy;
    logic             ready;
    logic [Q-1:0]     quotient;
    logic             sticky;
    logic [TAG_W-1:0] tag_o;

    int checks = 0;
    int errors = 0;

    fp_mant_divsqrt #(.WIDTH(WIDTH), .EXTRA(EXTRA), .TAG_W(TAG_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .kill     (kill),
        .op       (op),
        .odd      (odd),
        .a        (a),
        .b        (b),
        .tag_i    (tag_i),
        .busy     (busy),
        .ready    (ready),
        .quotient (quotient),
        .sticky   (sticky),
        .tag_o    (tag_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Result = {quotient, sticky} computed with plain integer arithmetic.
    function automatic logic [Q:0] ref_op(input logic o, input logic od,
                                          input logic [WIDTH-1:0] aa,
                                          input logic [WIDTH-1:0] bb);
        longint unsigned n, qv, r, t;
        logic            s;
        if (!o) begin
            n  = 64'(aa) << (Q - 1);
            qv = n / 64'(bb);
            s  = (n % 64'(bb)) != 0;
        end else begin
            n = (64'(aa) << od) << (2 * Q - 1 - WIDTH);
            r = 0;
            for (int i = Q; i >= 0; i--) begin
                t = r | (64'd1 << i);
                if (t * t <= n) r = t;
            end
            qv = r;
            s  = (r * r) != n;
        end
        return {qv[Q-1:0], s};
    endfunction

    // Behavioural timeline model: when the current job finishes, what is held.
    int           cyc = 0;
    bit           m_act = 0;
    int           m_done = 0;
    logic [Q-1:0] p_q = '0, e_q = '0;
    logic         p_s = 0, e_s = 0;
    logic [3:0]   p_t = '0, e_t = '0;
    bit           chk_en = 0;

    always @(posedge clock) begin
        int  c;
        bit  in_calc, in_done;
        logic [Q:0] rr;
        c       = cyc;
        in_calc = m_act && (c < m_done);
        in_done = m_act && (c == m_done);
        if (reset) begin
            m_act = 0;
            e_q   = '0;
            e_s   = 0;
            e_t   = '0;
        end else if (in_calc && kill) begin
            m_act = 0;
        end else begin
            if (in_calc && (c == m_done - 1)) begin
                e_q = p_q;
                e_s = p_s;
                e_t = p_t;
            end
            if (enable && !in_calc) begin
                rr     = ref_op(op, odd, a, b);
                p_q    = rr[Q:1];
                p_s    = rr[0];
                p_t    = tag_i;
                m_act  = 1;
                m_done = c + LAT;
            end else if (in_done) begin
                m_act = 0;
            end
        end
        cyc = c + 1;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_act && (cyc < m_done)));
            check("ready", 64'(ready), 64'(m_act && (cyc == m_done)));
            check("quotient", 64'(quotient), 64'(e_q));
            check("sticky", 64'(sticky), 64'(e_s));
            check("tag_o", 64'(tag_o), 64'(e_t));
        end
    end

    int acc_cyc;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic o, input logic od, input logic [23:0] aa,
                         input logic [23:0] bb, input logic [3:0] tg);
        op      = o;
        odd     = od;
        a       = aa;
        b       = bb;
        tag_i   = tg;
        enable  = 1'b1;
        acc_cyc = cyc;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check({nm, "_timeout"}, 64'(ready), 64'd1);
        check({nm, "_latency"}, 64'(cyc - acc_cyc), 64'(LAT));
    endtask

    task automatic run_dir(input string nm, input logic o, input logic od,
                           input logic [23:0] aa, input logic [23:0] bb,
                           input logic [3:0] tg, input logic [25:0] eq,
                           input logic es);
        issue(o, od, aa, bb, tg);
        wait_ready(nm);
        check({nm, "_q"}, 64'(quotient), 64'(eq));
        check({nm, "_sticky"}, 64'(sticky), 64'(es));
        check({nm, "_tag"}, 64'(tag_o), 64'(tg));
    endtask

    task automatic no_ready_for(input string nm, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (ready === 1'b1) seen++;
            tick();
        end
        check(nm, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        reset  = 1'b1;
        enable = 1'b0;
        kill   = 1'b0;
        op     = 1'b0;
        odd    = 1'b0;
        a      = 24'h800000;
        b      = 24'h800000;
        tag_i  = '0;

        check("pin_div_exact", 64'(ref_op(0, 0, 24'h800000, 24'h800000)),
              64'({26'h2000000, 1'b0}));
        check("pin_div_third", 64'(ref_op(0, 0, 24'h800000, 24'hC00000)),
              64'({26'h1555555, 1'b1}));
        check("pin_sqrt_even", 64'(ref_op(1, 0, 24'h800000, 24'h0)),
              64'({26'h2000000, 1'b0}));
        check("pin_sqrt_odd", 64'(ref_op(1, 1, 24'h800000, 24'h0)),
              64'({26'h2D413CC, 1'b1}));
        check("pin_sqrt_exact", 64'(ref_op(1, 1, 24'h900000, 24'h0)),
              64'({26'h3000000, 1'b0}));

        tick();
        chk_en = 1;
        tick();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        tick();

        run_dir("div_exact", 0, 0, 24'h800000, 24'h800000, 4'd5, 26'h2000000, 0);
        tick();
        run_dir("div_third", 0, 0, 24'h800000, 24'hC00000, 4'd2, 26'h1555555, 1);
        tick();
        run_dir("sqrt_even", 1, 0, 24'h800000, 24'h123456, 4'd6, 26'h2000000, 0);
        tick();
        run_dir("sqrt_odd", 1, 1, 24'h800000, 24'h0, 4'd11, 26'h2D413CC, 1);
        tick();

        // Second enable mid-calculation must be ignored.
        issue(0, 0, 24'h800000, 24'hC00000, 4'd3);
        repeat (9) tick();
        op     = 1'b1;
        a      = 24'h900000;
        tag_i  = 4'd12;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_ready("ignore_en");
        check("ignore_en_q", 64'(quotient), 64'h1555555);
        check("ignore_en_tag", 64'(tag_o), 64'd3);

        // Accept in the DONE cycle: back-to-back, no bubble.
        tick();
        run_dir("sqrt_exact", 1, 1, 24'h900000, 24'h0, 4'd8, 26'h3000000, 0);
        run_dir("b2b", 1, 0, 24'h800000, 24'h0, 4'd7, 26'h2000000, 0);
        tick();

        // Kill in cycle 5.
        issue(0, 0, 24'hFFFFFF, 24'h800001, 4'd4);
        repeat (4) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_hold_q", 64'(quotient), 64'h2000000);
        no_ready_for("kill_no_ready", 32);

        // Reset in cycle 12.
        issue(1, 1, 24'h800000, 24'h0, 4'd9);
        repeat (11) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_q", 64'(quotient), 64'd0);
        check("mid_rst_sticky", 64'(sticky), 64'd0);
        check("mid_rst_tag", 64'(tag_o), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd0);
        no_ready_for("rst_no_ready", 32);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 5000; i++) begin
            rnd    = $urandom();
            a      = {1'b1, rnd[22:0]};
            rnd    = $urandom();
            b      = {1'b1, rnd[22:0]};
            op     = rnd[31];
            odd    = rnd[30];
            tag_i  = rnd[27:24];
            enable = ($urandom_range(0, 5) == 0) ||
                     (ready && ($urandom_range(0, 1) == 1));
            kill   = ($urandom_range(0, 59) == 0);
            reset  = ($urandom_range(0, 999) == 0);
            tick();
        end
        enable = 1'b0;
        kill   = 1'b0;
        reset  = 1'b0;
        repeat (LAT + 4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
